seq_matmul_mac: RTL and testbench

- Parametrised sequential integer matrix multiplier: Z[M][N] = A[M][K] x B[K][N].
- Operands are signed, W bits wide. A and B are read from external synchronous-read memories (1-cycle read latency). Results stream out one element at a time on a stb/ack handshake.
- Generalises the square single-dimension float multiplier: independent M/K/N, configurable widths, one MAC per cycle while fetching, explicit output back-pressure, busy/done status.

---
 rtl/seq_matmul_mac.sv | 178 +++++++++++++++++
 tb/tb_seq_matmul_mac.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_matmul_mac.sv
// seq_matmul_mac: sequential signed matrix multiplier Z[M][N] = A[M][K] x B[K][N].
// A and B come from external 1-cycle-latency memories. The datapath does one MAC per
// cycle while fetching. Results stream out one element at a time on a stb/ack handshake.
// Build macro MATMUL_SAT_EN: when defined, each result is saturated to the signed OUT_W
// range. When undefined, each result keeps the low OUT_W bits (two's-complement wrap).
module seq_matmul_mac #(
  parameter int M     = 4,
  parameter int K     = 4,
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int OUT_W = 2*W + $clog2(K) + 1,
  localparam int IM   = (M > 1) ? $clog2(M) : 1,
  localparam int IK   = (K > 1) ? $clog2(K) : 1,
  localparam int IN   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rd_en,
  output logic [IM-1:0]    a_i,
  output logic [IK-1:0]    a_j,
  output logic [IK-1:0]    b_i,
  output logic [IN-1:0]    b_j,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic [OUT_W-1:0] z_out,
  output logic [IM-1:0]    z_i,
  output logic [IN-1:0]    z_j,
  output logic             z_stb,
  input  logic             z_ack,
  output logic             busy,
  output logic             done
);

  // The accumulator is wide enough for every possible dot product, even when OUT_W is narrowed.
  localparam int FULL_W = 2*W + $clog2(K) + 1;
  localparam int ACC_W  = (OUT_W + 1 > FULL_W) ? OUT_W + 1 : FULL_W;

  localparam logic [IM-1:0] M_LAST = IM'(M - 1);
  localparam logic [IK-1:0] K_LAST = IK'(K - 1);
  localparam logic [IN-1:0] N_LAST = IN'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [IM-1:0]           r_i;
  logic [IN-1:0]           r_j;
  logic [IK-1:0]           r_k;
  logic                    r_vldD;
  logic signed [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0]        r_zOut;
  logic                    r_zStb;

  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prodExt;
  logic signed [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0]        w_zNext;
  logic                    w_lastElem;

  assign w_prod     = $signed(a_in) * $signed(b_in);
  assign w_prodExt  = {{(ACC_W - 2*W){w_prod[2*W-1]}}, w_prod};
  assign w_sum      = r_acc + w_prodExt;
  assign w_lastElem = (r_j == N_LAST) && (r_i == M_LAST);

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  // Clamp the finished dot product into the signed OUT_W range.
  always_comb begin
    w_zNext = w_sum[OUT_W-1:0];
    if (w_sum > SAT_MAX) begin
      w_zNext = OUT_MAX;
    end else if (w_sum < SAT_MIN) begin
      w_zNext = OUT_MIN;
    end
  end
`else
  assign w_zNext = w_sum[OUT_W-1:0];
`endif

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: K fetch cycles, one drain cycle, then wait for the consumer.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (start) w_stateNext = S_RUN;
      S_RUN:   if (r_k == K_LAST) w_stateNext = S_DRAIN;
      S_DRAIN: w_stateNext = S_OUT;
      S_OUT:   if (z_ack) w_stateNext = w_lastElem ? S_DONE : S_RUN;
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Status and read-strobe outputs are decoded directly from the state.
  always_comb begin
    rd_en = (r_state == S_RUN);
    busy  = (r_state != S_IDLE);
    done  = (r_state == S_DONE);
  end

  // Datapath: index walking, accumulation of delayed read data, and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_vldD <= 1'b0;
      r_acc  <= '0;
      r_zOut <= '0;
      r_zStb <= 1'b0;
    end else begin
      r_vldD <= rd_en;
      if (r_vldD) begin
        r_acc <= w_sum;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        S_RUN: begin
          r_k <= (r_k == K_LAST) ? '0 : r_k + IK'(1);
        end
        S_DRAIN: begin
          r_zOut <= w_zNext;
          r_zStb <= 1'b1;
        end
        S_OUT: begin
          if (z_ack) begin
            r_zStb <= 1'b0;
            r_acc  <= '0;
            if (r_j != N_LAST) begin
              r_j <= r_j + IN'(1);
            end else if (r_i != M_LAST) begin
              r_j <= '0;
              r_i <= r_i + IM'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign a_i   = r_i;
  assign a_j   = r_k;
  assign b_i   = r_k;
  assign b_j   = r_j;
  assign z_i   = r_i;
  assign z_j   = r_j;
  assign z_out = r_zOut;
  assign z_stb = r_zStb;

endmodule

// File: tb/tb_seq_matmul_mac.sv
// tb_seq_matmul_mac: randomized self-checking bench for seq_matmul_mac.
// Three differently-sized instances share clock, reset and operand memories.
// Only the instance selected by 'sel' is driven at any time.
// Expected results come from a plain dot-product model over the memory arrays.
// That model honours MATMUL_SAT_EN in the same way the design is built.
module tb_seq_matmul_mac;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   sel = 0;
  logic startReq = 1'b0;
  logic ackReq = 1'b0;

  int errors = 0;
  int checks = 0;

  int memA[4][4];
  int memB[4][4];

  // Instance 0: M=2 K=3 N=2 W=16, default OUT_W (35)
  logic start0, rdEn0, zStb0, zAck0, busy0, done0;
  logic [0:0]  aI0, bJ0, zI0, zJ0;
  logic [1:0]  aJ0, bI0;
  logic [15:0] aIn0 = '0, bIn0 = '0;
  logic [34:0] zOut0;

  // Instance 1: M=2 K=4 N=3 W=8 OUT_W=8 (narrow output, overflow possible)
  logic start1, rdEn1, zStb1, zAck1, busy1, done1;
  logic [0:0]  aI1, zI1;
  logic [1:0]  aJ1, bI1, bJ1, zJ1;
  logic [7:0]  aIn1 = '0, bIn1 = '0;
  logic [7:0]  zOut1;

  // Instance 2: M=3 K=1 N=1 W=8, default OUT_W (17)
  logic start2, rdEn2, zStb2, zAck2, busy2, done2;
  logic [1:0]  aI2, zI2;
  logic [0:0]  aJ2, bI2, bJ2, zJ2;
  logic [7:0]  aIn2 = '0, bIn2 = '0;
  logic [16:0] zOut2;

  assign start0 = startReq && (sel == 0);
  assign start1 = startReq && (sel == 1);
  assign start2 = startReq && (sel == 2);
  assign zAck0  = ackReq && (sel == 0);
  assign zAck1  = ackReq && (sel == 1);
  assign zAck2  = ackReq && (sel == 2);

  seq_matmul_mac #(.M(2), .K(3), .N(2), .W(16)) u0 (
    .clk(clk), .rst(rst), .start(start0), .rd_en(rdEn0),
    .a_i(aI0), .a_j(aJ0), .b_i(bI0), .b_j(bJ0), .a_in(aIn0), .b_in(bIn0),
    .z_out(zOut0), .z_i(zI0), .z_j(zJ0), .z_stb(zStb0), .z_ack(zAck0),
    .busy(busy0), .done(done0)
  );

  seq_matmul_mac #(.M(2), .K(4), .N(3), .W(8), .OUT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .rd_en(rdEn1),
    .a_i(aI1), .a_j(aJ1), .b_i(bI1), .b_j(bJ1), .a_in(aIn1), .b_in(bIn1),
    .z_out(zOut1), .z_i(zI1), .z_j(zJ1), .z_stb(zStb1), .z_ack(zAck1),
    .busy(busy1), .done(done1)
  );

  seq_matmul_mac #(.M(3), .K(1), .N(1), .W(8)) u2 (
    .clk(clk), .rst(rst), .start(start2), .rd_en(rdEn2),
    .a_i(aI2), .a_j(aJ2), .b_i(bI2), .b_j(bJ2), .a_in(aIn2), .b_in(bIn2),
    .z_out(zOut2), .z_i(zI2), .z_j(zJ2), .z_stb(zStb2), .z_ack(zAck2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // Synchronous-read operand memories, one read port pair per instance
  always @(posedge clk) begin
    if (rdEn0) begin
      aIn0 <= 16'(memA[aI0][aJ0]);
      bIn0 <= 16'(memB[bI0][bJ0]);
    end
    if (rdEn1) begin
      aIn1 <= 8'(memA[aI1][aJ1]);
      bIn1 <= 8'(memB[bI1][bJ1]);
    end
    if (rdEn2) begin
      aIn2 <= 8'(memA[aI2][aJ2]);
      bIn2 <= 8'(memB[bI2][bJ2]);
    end
  end

  // Observation mux so the checking code is instance-agnostic
  longint obsZ;
  int     obsI, obsJ;
  logic   obsStb, obsBusy, obsDone, obsRdEn;
  always_comb begin
    obsZ = 0; obsI = 0; obsJ = 0;
    obsStb = 1'b0; obsBusy = 1'b0; obsDone = 1'b0; obsRdEn = 1'b0;
    case (sel)
      0: begin
        obsZ = $signed(zOut0); obsI = int'(zI0); obsJ = int'(zJ0);
        obsStb = zStb0; obsBusy = busy0; obsDone = done0; obsRdEn = rdEn0;
      end
      1: begin
        obsZ = $signed(zOut1); obsI = int'(zI1); obsJ = int'(zJ1);
        obsStb = zStb1; obsBusy = busy1; obsDone = done1; obsRdEn = rdEn1;
      end
      default: begin
        obsZ = $signed(zOut2); obsI = int'(zI2); obsJ = int'(zJ2);
        obsStb = zStb2; obsBusy = busy2; obsDone = done2; obsRdEn = rdEn2;
      end
    endcase
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: exact dot product, then saturate or wrap into OUT_W bits
  function automatic longint refElem(input int i, input int j, input int kk, input int outW);
    longint s = 0;
    longint lim;
    for (int k = 0; k < kk; k++) begin
      s += longint'(memA[i][k]) * longint'(memB[k][j]);
    end
    lim = longint'(1) <<< (outW - 1);
`ifdef MATMUL_SAT_EN
    if (s > lim - 1) s = lim - 1;
    else if (s < -lim) s = -lim;
`else
    s = s & ((lim <<< 1) - 1);
    if (s >= lim) s -= (lim <<< 1);
`endif
    return s;
  endfunction

  // Random signed W-bit value, biased toward the extremes
  function automatic int randW(input int ww);
    int r;
    int half = 1 << (ww - 1);
    case ($urandom_range(0, 5))
      0: r = half - 1;
      1: r = -half;
      default: begin
        r = int'($urandom_range(0, (1 << ww) - 1));
        if (r >= half) r -= (1 << ww);
      end
    endcase
    return r;
  endfunction

  task automatic fillRandom(input int ww);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        memA[a][b] = randW(ww);
        memB[a][b] = randW(ww);
      end
    end
  endtask

  task automatic fillConst(input int v);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        memA[a][b] = v;
        memB[a][b] = v;
      end
    end
  endtask

  // Runs one multiplication on instance 'dut' and scoreboards every streamed element.
  // ackWait = number of OUT cycles the ack is withheld (0 means ack tied high).
  // abortIdx >= 0 drops reset when that element first appears and returns immediately.
  task automatic applyStimulus(input int dut, input int mm, input int kk, input int nn,
                               input int outW, input int ackWait, input bit midStart,
                               input int abortIdx);
    int cycles = 0, idx = 0, stall = 0, firstStb = -1, lastStb = -1;
    int doneCnt = 0, stableErr = 0, rdErr = 0;
    longint heldZ = 0;
    int heldI = 0, heldJ = 0;
    bit finished = 1'b0;
    sel = dut;
    @(negedge clk);
    ackReq = (ackWait == 0);
    startReq = 1'b1;
    while (!finished && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      startReq = midStart && (cycles >= 3) && (cycles < 6);
      if (obsDone) doneCnt++;
      if (obsStb) begin
        if (obsRdEn) rdErr++;
        if (stall == 0) begin
          if (idx == abortIdx) begin
            rst = 1'b0;
            startReq = 1'b0;
            ackReq = 1'b0;
            #1;
            checkOutput("abortStb", longint'(obsStb), 0);
            checkOutput("abortBusy", longint'(obsBusy), 0);
            checkOutput("abortZout", obsZ, 0);
            return;
          end
          if (idx < mm * nn) begin
            checkOutput($sformatf("z[%0d][%0d]", idx / nn, idx % nn), obsZ,
                        refElem(idx / nn, idx % nn, kk, outW));
            checkOutput($sformatf("zi#%0d", idx), longint'(obsI), longint'(idx / nn));
            checkOutput($sformatf("zj#%0d", idx), longint'(obsJ), longint'(idx % nn));
          end
          if (ackWait == 0 && lastStb >= 0) begin
            checkOutput($sformatf("spacing#%0d", idx), longint'(cycles - lastStb), longint'(kk + 2));
          end
          if (firstStb < 0) firstStb = cycles;
          lastStb = cycles;
          heldZ = obsZ;
          heldI = obsI;
          heldJ = obsJ;
          idx++;
        end else if (obsZ != heldZ || obsI != heldI || obsJ != heldJ) begin
          stableErr++;
        end
        if (stall >= ackWait) begin
          ackReq = 1'b1;
          stall = 0;
        end else begin
          ackReq = 1'b0;
          stall++;
        end
      end else if (ackWait > 0) begin
        ackReq = 1'($urandom_range(0, 1));
      end
      if (!obsBusy) finished = 1'b1;
    end
    startReq = 1'b0;
    ackReq = 1'b0;
    checkOutput("finished", longint'(finished), 1);
    checkOutput("elemCount", longint'(idx), longint'(mm * nn));
    checkOutput("donePulses", longint'(doneCnt), 1);
    checkOutput("firstStbEdge", longint'(firstStb), longint'(kk + 2));
    checkOutput("heldStable", longint'(stableErr), 0);
    checkOutput("rdEnInOut", longint'(rdErr), 0);
    if (ackWait == 0) begin
      checkOutput("totalCycles", longint'(cycles), longint'(mm * nn * (kk + 2) + 2));
    end
  endtask

  initial begin
    // Reset state of the main instance while rst is held low
    #3;
    checkOutput("rstZout", obsZ, 0);
    checkOutput("rstStb", longint'(obsStb), 0);
    checkOutput("rstBusy", longint'(obsBusy), 0);
    checkOutput("rstDone", longint'(obsDone), 0);
    checkOutput("rstRdEn", longint'(obsRdEn), 0);
    checkOutput("rstZi", longint'(obsI), 0);
    checkOutput("rstZj", longint'(obsJ), 0);
    checkOutput("rstAddr", longint'({aI0, aJ0, bI0, bJ0}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idleBusy", longint'(obsBusy), 0);

    // Fixed 2x3 * 3x2 product, ack tied high, then with a 6-cycle ack stall
    fillConst(0);
    memA[0][0] = 1; memA[0][1] = 2; memA[0][2] = 3;
    memA[1][0] = 4; memA[1][1] = 5; memA[1][2] = 6;
    memB[0][0] = 7;  memB[0][1] = 8;
    memB[1][0] = 9;  memB[1][1] = 10;
    memB[2][0] = 11; memB[2][1] = 12;
    applyStimulus(0, 2, 3, 2, 35, 0, 1'b0, -1);
    applyStimulus(0, 2, 3, 2, 35, 6, 1'b0, -1);

    // start held high mid-run must be ignored
    applyStimulus(0, 2, 3, 2, 35, 0, 1'b1, -1);

    // Reset during OUT of element (0,1), then a clean restart
    applyStimulus(0, 2, 3, 2, 35, 3, 1'b0, 1);
    @(negedge clk);
    checkOutput("postAbortBusy", longint'(obsBusy), 0);
    rst = 1'b1;
    applyStimulus(0, 2, 3, 2, 35, 0, 1'b0, -1);

    // Signed extremes (third inner term zero)
    fillConst(0);
    memA[0][0] = -128; memA[0][1] = 127;
    memA[1][0] = -1;   memA[1][1] = 0;
    memB[0][0] = -128; memB[0][1] = -1;
    memB[1][0] = 127;  memB[1][1] = 2;
    applyStimulus(0, 2, 3, 2, 35, 0, 1'b0, -1);

    // Randomized runs on the wide instance
    for (int r = 0; r < 4; r++) begin
      fillRandom(16);
      applyStimulus(0, 2, 3, 2, 35, int'($urandom_range(0, 3)), 1'b0, -1);
    end

    // Narrow output: all 127 overflows OUT_W=8 (saturates or wraps to 4)
    fillConst(127);
    applyStimulus(1, 2, 4, 3, 8, 0, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      fillRandom(8);
      applyStimulus(1, 2, 4, 3, 8, int'($urandom_range(0, 2)), 1'b0, -1);
    end

    // K=1, single column: three elements three cycles apart
    for (int r = 0; r < 2; r++) begin
      fillRandom(8);
      applyStimulus(2, 3, 1, 1, 17, 0, 1'b0, -1);
    end
    applyStimulus(2, 3, 1, 1, 17, 2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
